// File: rtl/aes_128_decrypt.sv
// rtl/aes_128_decrypt.sv - iterative AES-128 inverse cipher, one round per clock
// Key is expanded forward to rk10, then unwound in reverse alongside the decrypt rounds.

module sub_bytes (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // entry a sits at bits [8*(255-a)+7 -: 8]
  assign y = SBOX[{~a, 3'b111} -: 8];
endmodule

module inv_sub_bytes (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  assign y = INV_SBOX[{~a, 3'b111} -: 8];
endmodule

module aes_128_decrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] master_key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] KEYX  = 3'd1;
  localparam logic [2:0] INIT  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] FINAL = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]   state;
  logic [3:0]   cnt;
  logic [127:0] s;
  logic [127:0] rk;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // k selects which of b, 2b, 4b, 8b are summed (k=4'hE gives 0e, etc.)
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul = (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    inv_mix_col = {
      gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
      gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
      gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
      gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
    };
  endfunction

  logic [31:0]  k0, k1, k2, k3;
  logic [31:0]  p1, p2, p3;
  logic [31:0]  sub_in, rot, sub_out, sw;
  logic [127:0] fwd_key, rev_key;

  assign {k0, k1, k2, k3} = rk;
  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // One set of four S-boxes serves both directions of the key schedule
  assign sub_in = (state == KEYX) ? k3 : p3;
  assign rot    = {sub_in[23:0], sub_in[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    sub_bytes u_sub_bytes (.a(rot[8*i+7 -: 8]), .y(sub_out[8*i+7 -: 8]));
  end

  assign sw      = sub_out ^ {rcon(cnt), 24'h000000};
  assign fwd_key = {k0 ^ sw, k0 ^ sw ^ k1, k0 ^ sw ^ k1 ^ k2, k0 ^ sw ^ k1 ^ k2 ^ k3};
  assign rev_key = {k0 ^ sw, p1, p2, p3};

  logic [127:0] isr, isb, ark, imc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign isr[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      inv_sub_bytes u_inv_sub_bytes (.a(isr[127-8*(4*c+r) -: 8]), .y(isb[127-8*(4*c+r) -: 8]));
    end
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign ark = isb ^ rk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      s         <= 128'd0;
      rk        <= 128'd0;
      plaintext <= 128'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s     <= ciphertext;
            rk    <= master_key;
            cnt   <= 4'd1;
            state <= KEYX;
          end
        end
        KEYX: begin
          rk <= fwd_key;
          // cnt stays at 10 so INIT unwinds rk10 with Rcon[10]
          if (cnt == 4'd10) state <= INIT;
          else cnt <= cnt + 4'd1;
        end
        INIT: begin
          s     <= s ^ rk;
          rk    <= rev_key;
          cnt   <= 4'd9;
          state <= ROUND;
        end
        ROUND: begin
          s   <= imc;
          rk  <= rev_key;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= FINAL;
        end
        FINAL: begin
          plaintext <= ark;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == KEYX) || (state == INIT) || (state == ROUND) || (state == FINAL);
  assign done = (state == DONE);
endmodule

// File: tb/tb_aes_128_decrypt.sv
// tb/tb_aes_128_decrypt.sv - directed and loopback checks of aes_128_decrypt
// Uses an independent forward AES-128 model to produce loopback ciphertexts.

module tb_aes_128_decrypt;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] master_key = '0;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_128_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .master_key (master_key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] a);
    return SB[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] rk, s, t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  w;
    rk = key;
    s  = pt ^ key;
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      w = {sb(rk[23:16]), sb(rk[15:8]), sb(rk[7:0]), sb(rk[31:24])} ^ {rc, 24'h000000};
      rk[127:96] = rk[127:96] ^ w;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      rc = xt(rc);
      for (int i = 0; i < 16; i++)
        t[127-8*i -: 8] = sb(s[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8]);
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8];
          a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8];
          a3 = t[103-32*c -: 8];
          t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [127:0] k, input logic [127:0] c);
    master_key = k;
    ciphertext = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [127:0] k, p, c;

    tick();
    tick();
    check("reset_plaintext", plaintext, 128'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_cnt", dut.cnt, 4'd0);
    check("reset_rk", dut.rk, 128'd0);
    rst = 1'b0;
    tick();

    // FIPS-197 C.1
    launch(C1_KEY, C1_CT);
    check("c1_busy_after_accept", busy, 1'b1);
    master_key = '0;
    for (int i = 1; i <= 10; i++) tick();
    check("c1_rk10_at_init", dut.rk, C1_RK10);
    wait_done(10, lat);
    check("c1_latency", lat, 21);
    check("c1_plaintext", plaintext, C1_PT);
    check("c1_busy_in_done", busy, 1'b0);
    tick();
    check("c1_done_width", done, 1'b0);
    check("c1_plaintext_held", plaintext, C1_PT);

    // FIPS-197 App. B
    launch(B_KEY, B_CT);
    for (int i = 1; i <= 10; i++) tick();
    check("b_rk10_at_init", dut.rk, B_RK10);
    wait_done(10, lat);
    check("b_latency", lat, 21);
    check("b_plaintext", plaintext, B_PT);
    tick();

    // start held high: ciphertext change mid-run must not leak into the result
    master_key = C1_KEY;
    ciphertext = C1_CT;
    start = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) tick();
    ciphertext = '0;
    wait_done(5, lat);
    check("held_latency", lat, 21);
    check("held_plaintext", plaintext, C1_PT);
    check("held_busy_in_done", busy, 1'b0);
    ciphertext = C1_CT;
    tick();
    check("held_idle_done", done, 1'b0);
    check("held_idle_busy", busy, 1'b0);
    tick();
    check("held_reaccept_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(0, lat);
    check("held_second_latency", lat, 21);
    check("held_second_plaintext", plaintext, C1_PT);
    tick();

    // reset in the middle of a run
    launch(B_KEY, B_CT);
    for (int i = 1; i <= 10; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_plaintext", plaintext, 128'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_state", dut.state, 3'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    launch(B_KEY, B_CT);
    wait_done(0, lat);
    check("midrst_restart_latency", lat, 21);
    check("midrst_restart_plaintext", plaintext, B_PT);
    tick();

    // start pulses while busy are ignored
    launch(C1_KEY, C1_CT);
    ndone = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      start = (cyc == 3 || cyc == 15 || cyc == 20);
      ciphertext = start ? 128'd0 : C1_CT;
      tick();
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    check("pulses_one_done", ndone, 1);
    check("pulses_plaintext", plaintext, C1_PT);
    check("pulses_idle_busy", busy, 1'b0);

    // loopback against the forward model
    for (int n = 0; n < 200; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = aes_enc(k, p);
      launch(k, c);
      wait_done(0, lat);
      check("loopback_plaintext", plaintext, p);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
